addsubfxp_sat_obf: RTL

- Parametrised successor of the team's single-stage locked fixed-point adder.
- Signed two's-complement add/subtract with a runtime op select and optional saturation.
- Configurable pipeline depth with valid tracking, per-result overflow flag, and a saturating overflow event counter.
- Function is gated by a 2-bit locking key; only the correct key (2'b11) yields specified arithmetic. Sits in fixed-point datapaths (filters, FFT butterflies) as the locked adder primitive.

---
 rtl/addsubfxp_sat_obf_if.sv | 28 ++
 rtl/addsubfxp_sat_obf.sv | 85 ++++++++
 2 files changed

// File: rtl/addsubfxp_sat_obf_if.sv
// Operand/result bundle for the locked saturating fixed-point add/sub primitive.
// The master drives operands and controls; the slave (the adder) returns results.
interface addsubfxp_sat_obf_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat_en;
  logic             cnt_clr;
  logic [1:0]       working_locking_key;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic             ovf;
  logic [CNT_W-1:0] ovf_cnt;

  modport master (
    output in_valid, a, b, sub, sat_en, cnt_clr, working_locking_key,
    input  q, out_valid, ovf, ovf_cnt
  );

  modport slave (
    input  in_valid, a, b, sub, sat_en, cnt_clr, working_locking_key,
    output q, out_valid, ovf, ovf_cnt
  );
endinterface

// File: rtl/addsubfxp_sat_obf.sv
// Key-locked signed add/subtract with optional saturation, a CYCLES-deep valid-tracked
// pipeline, a per-result overflow flag and a saturating overflow event counter.
module addsubfxp_sat_obf #(
  parameter int WIDTH  = 16,
  parameter int CYCLES = 1,
  parameter int CNT_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  addsubfxp_sat_obf_if.slave bus
);

  localparam int LAST = CYCLES - 1;

  typedef struct packed {
    logic             valid;
    logic             ovf;
    logic [WIDTH-1:0] data;
  } stage_t;

  logic                 eff_sub;
  logic                 eff_sat;
  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic signed [WIDTH:0] sum;
  logic                 ovf_d;
  logic [WIDTH-1:0]     res_d;

  stage_t               pipe_q [CYCLES];
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  // A wrong key silently inverts the operation and disables saturation.
  always_comb begin
    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    eff_sub = bus.sub ^ ~bus.working_locking_key[0];
    eff_sat = bus.sat_en & bus.working_locking_key[1];
    a_ext   = {bus.a[WIDTH-1], bus.a};
    b_ext   = {bus.b[WIDTH-1], bus.b};
    sum     = eff_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf_d   = sum[WIDTH] ^ sum[WIDTH-1];
    res_d   = sum[WIDTH-1:0];
    if (ovf_d && eff_sat) begin
      res_d = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage registers are a short flop chain, not a RAM, so they are all reset and q reads 0.
      for (int i = 0; i < CYCLES; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: bus.in_valid, ovf: ovf_d, data: res_d};
      for (int i = 1; i < CYCLES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (pipe_q[LAST].valid && pipe_q[LAST].ovf && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.q         = pipe_q[LAST].data;
  assign bus.out_valid = pipe_q[LAST].valid;
  assign bus.ovf       = pipe_q[LAST].ovf;
  assign bus.ovf_cnt   = cnt_q;

endmodule
